// File: rtl/npu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : npu_tile_sequencer
// Purpose  : Instruction-driven control sequencer for one NPU tile. Queues
//            instructions in a small FIFO and, per instruction, loads weight
//            rows into the PE array, runs compute, stores results, or waits
//            on a DMA transfer with a timeout.
// Ports    : clk, rst               - clock, asynchronous active-high reset
//            start, enable          - begin a run / global advance enable
//            busy, done, irq_error  - status and one-cycle event pulses
//            err_code               - sticky error cause (1 illegal, 2 DMA)
//            inst_*                 - instruction push interface (valid/ready)
//            fifo_level             - number of queued instructions
//            pe_*                   - PE array controls
//            wbuf_*, abuf_*         - weight-buffer read / act-buffer write
//            dma_start, dma_done    - DMA handshake
// Revision : 1.0 - initial release
// ============================================================================
module npu_tile_sequencer #(
    parameter int PE_ROWS     = 16,
    parameter int INST_DEPTH  = 4,
    parameter int ADDR_W      = 18,
    parameter int CNT_W       = 16,
    parameter int DMA_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          enable,
    output logic                          busy,
    output logic                          done,
    output logic                          irq_error,
    output logic [1:0]                    err_code,
    input  logic                          inst_valid,
    output logic                          inst_ready,
    input  logic [3:0]                    inst_opcode,
    input  logic [ADDR_W-1:0]             inst_src,
    input  logic [ADDR_W-1:0]             inst_dst,
    input  logic [CNT_W-1:0]              inst_len,
    input  logic [7:0]                    inst_tiles,
    output logic [$clog2(INST_DEPTH):0]   fifo_level,
    output logic [PE_ROWS-1:0]            pe_load_weight,
    output logic                          pe_enable,
    output logic                          pe_clear_acc,
    output logic                          wbuf_rd_en,
    output logic [ADDR_W-1:0]             wbuf_addr,
    output logic                          abuf_wr_en,
    output logic [ADDR_W-1:0]             abuf_addr,
    output logic                          dma_start,
    input  logic                          dma_done
);

    localparam int c_PTR_W  = $clog2(INST_DEPTH);
    localparam int c_LVL_W  = c_PTR_W + 1;
    localparam int c_ROW_W  = (PE_ROWS > 1) ? $clog2(PE_ROWS) : 1;
    localparam int c_TMR_W  = $clog2(DMA_TIMEOUT + 1);
    localparam int c_INST_W = 4 + 2 * ADDR_W + CNT_W + 8;

    localparam logic [3:0] c_OP_NOP    = 4'd0;
    localparam logic [3:0] c_OP_MATMUL = 4'd1;
    localparam logic [3:0] c_OP_LOAD   = 4'd2;
    localparam logic [3:0] c_OP_SYNC   = 4'd3;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_LOAD_W   = 4'd3,
        S_COMPUTE  = 4'd4,
        S_STORE    = 4'd5,
        S_DMA_WAIT = 4'd6,
        S_DONE     = 4'd7,
        S_ERROR    = 4'd8
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------------
    logic [c_INST_W-1:0] r_mem [INST_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_count;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;

    logic [3:0]          w_h_op;
    logic [ADDR_W-1:0]   w_h_src;
    logic [ADDR_W-1:0]   w_h_dst;
    logic [CNT_W-1:0]    w_h_len;
    logic [7:0]          w_h_tiles;

    assign w_full     = (r_count == c_LVL_W'(INST_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = inst_valid && !w_full;
    assign w_pop      = enable && (r_state == S_FETCH) && !w_empty;
    // Queue is discarded on the transition into ERROR; ERROR only exits to
    // IDLE, so the state guard makes this a single-cycle event.
    assign w_flush    = (w_state_next == S_ERROR) && (r_state != S_ERROR);
    assign inst_ready = !w_full;
    assign fifo_level = r_count;

    assign {w_h_op, w_h_src, w_h_dst, w_h_len, w_h_tiles} = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push && !w_flush) begin
            r_mem[r_wr_ptr] <= {inst_opcode, inst_src, inst_dst, inst_len, inst_tiles};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_LVL_W'(1);
                2'b01:   r_count <= r_count - c_LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Instruction register and sequencing counters
    // ------------------------------------------------------------------------
    logic [3:0]         r_op;
    logic [ADDR_W-1:0]  r_src;
    logic [ADDR_W-1:0]  r_dst;
    logic [CNT_W-1:0]   r_len;
    logic [7:0]         r_tiles;
    logic [c_ROW_W-1:0] r_row;
    logic [7:0]         r_tile;
    logic [CNT_W-1:0]   r_cnt;
    logic [c_TMR_W-1:0] r_timer;
    logic [1:0]         r_err;

    logic               w_last_row;
    logic               w_last_cnt;
    logic               w_last_tile;
    logic               w_timeout;
    logic [7:0]         w_tiles_eff;
    logic [8:0]         w_tile_inc;

    assign w_last_row  = (r_row == c_ROW_W'(PE_ROWS - 1));
    assign w_last_cnt  = (r_cnt == (r_len - CNT_W'(1)));
    // A tile count of zero still runs one tile.
    assign w_tiles_eff = (r_tiles == 8'd0) ? 8'd1 : r_tiles;
    assign w_tile_inc  = {1'b0, r_tile} + 9'd1;
    assign w_last_tile = (w_tile_inc >= {1'b0, w_tiles_eff});
    assign w_timeout   = (r_timer == c_TMR_W'(DMA_TIMEOUT - 1));

    assign wbuf_addr = r_src + (ADDR_W'(r_tile) * ADDR_W'(PE_ROWS)) + ADDR_W'(r_row);
    assign abuf_addr = r_dst + ADDR_W'(r_tile);
    assign busy      = (r_state != S_IDLE);
    assign err_code  = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_tiles <= '0;
            r_row   <= '0;
            r_tile  <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
            r_err   <= '0;
        end else begin
            if (w_pop) begin
                r_op    <= w_h_op;
                r_src   <= w_h_src;
                r_dst   <= w_h_dst;
                r_len   <= w_h_len;
                r_tiles <= w_h_tiles;
            end
            if (enable) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) r_err <= 2'd0;
                    end
                    S_DECODE: begin
                        r_row   <= '0;
                        r_tile  <= '0;
                        r_cnt   <= '0;
                        r_timer <= '0;
                        if (w_state_next == S_ERROR) r_err <= 2'd1;
                    end
                    S_LOAD_W: begin
                        r_cnt <= '0;
                        if (w_last_row) r_row <= '0;
                        else            r_row <= r_row + c_ROW_W'(1);
                    end
                    S_COMPUTE: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    S_STORE: begin
                        r_tile <= r_tile + 8'd1;
                        r_row  <= '0;
                    end
                    S_DMA_WAIT: begin
                        r_timer <= r_timer + c_TMR_W'(1);
                        // dma_done on the final wait cycle counts as success.
                        if (!dma_done && w_timeout) r_err <= 2'd2;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Every advance and every strobe is qualified by enable so that a low
    // enable freezes the sequence with all datapath strobes quiet.
    always_comb begin
        w_state_next   = r_state;
        pe_load_weight = '0;
        pe_enable      = 1'b0;
        pe_clear_acc   = 1'b0;
        wbuf_rd_en     = 1'b0;
        abuf_wr_en     = 1'b0;
        dma_start      = 1'b0;
        done           = 1'b0;
        irq_error      = 1'b0;
        if (enable) begin
            case (r_state)
                S_IDLE: begin
                    if (start) w_state_next = S_FETCH;
                end
                S_FETCH: begin
                    if (!w_empty) w_state_next = S_DECODE;
                end
                S_DECODE: begin
                    case (r_op)
                        c_OP_NOP:    w_state_next = S_FETCH;
                        c_OP_MATMUL: begin
                            w_state_next = S_LOAD_W;
                            pe_clear_acc = 1'b1;
                        end
                        c_OP_LOAD:   w_state_next = S_DMA_WAIT;
                        c_OP_SYNC:   w_state_next = S_DONE;
                        default:     w_state_next = S_ERROR;
                    endcase
                end
                S_LOAD_W: begin
                    wbuf_rd_en     = 1'b1;
                    pe_load_weight = PE_ROWS'(1) << r_row;
                    if (w_last_row) begin
                        w_state_next = (r_len == '0) ? S_STORE : S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    pe_enable = 1'b1;
                    if (w_last_cnt) w_state_next = S_STORE;
                end
                S_STORE: begin
                    abuf_wr_en = 1'b1;
                    if (w_last_tile) begin
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_LOAD_W;
                        pe_clear_acc = 1'b1;
                    end
                end
                S_DMA_WAIT: begin
                    // Timer is zero only on the first DMA_WAIT cycle.
                    dma_start = (r_timer == '0);
                    if (dma_done)       w_state_next = S_FETCH;
                    else if (w_timeout) w_state_next = S_ERROR;
                end
                S_DONE: begin
                    done         = 1'b1;
                    w_state_next = S_IDLE;
                end
                S_ERROR: begin
                    irq_error    = 1'b1;
                    w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
